iram_loader: RTL and testbench
==============================

Name: iram_loader

Overview:
- Upstream stage of the processor top level.
- Receives a byte stream from a host link, for example a UART receiver, over a valid/ready handshake.
- Assembles the bytes into 16-bit instruction words and writes them into the instruction RAM at addresses 0..N-1.
- Once the program image is fully loaded, raises the core `start` level so execution begins at PC 0.

Parameters:
- ADDR_W, 9, IRAM address width; matches the 9-bit IRAM address.
- DEPTH, 512, maximum words accepted; must be ≤ 2^ADDR_W.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle.
- iram_we  out  1  IRAM write enable; one-cycle pulse per word.
- iram_addr  out  ADDR_W  IRAM write address.
- iram_wdata  out  16  IRAM write data.
- core_start  out  1  start level to the core.
- busy  out  1  load in progress.
- error  out  1  sticky load error.

Behaviour:
- Reset: with rst_n low at an edge, the state goes to IDLE and every output clears to 0. This holds mid-load too; partial IRAM contents are left as they are.
- Handshake: a byte is accepted when rx_valid && rx_ready. rx_data is sampled only on acceptance.
- rx_ready = 1 in IDLE, HDR_LO, DATA_HI, DATA_LO and CHK. It is 0 in WRITE, DONE and ERR.
- Stream format, big-endian:
  - Count high byte, then count low byte, giving N.
  - Then N words, each sent as high byte then low byte.
- State machine (idx is a word counter of width ADDR_W+1):
  - IDLE: accept byte into cnt[15:8] → HDR_LO.
  - HDR_LO: accept byte into cnt[7:0].
    - If the full count is 0 or greater than DEPTH → ERR.
    - Otherwise idx=0, → DATA_HI.
  - DATA_HI: accept byte into word[15:8] → DATA_LO.
  - DATA_LO: accept byte into word[7:0] → WRITE.
  - WRITE: exactly one cycle.
    - Drive iram_we=1, iram_addr=idx[ADDR_W-1:0], iram_wdata=word.
    - Increment idx.
    - If idx+1==cnt → DONE (or CHK, see Optional Feature); otherwise → DATA_HI.
  - DONE: core_start=1, held until reset. Further bytes are not accepted.
  - ERR: error=1, core_start=0, held until reset.
- Latency: iram_we asserts in the cycle after the low byte is accepted. With a continuous stream, each word costs 3 cycles.
- Outputs are registered.
  - iram_addr/iram_wdata hold their last values when iram_we=0.
  - busy=1 in every state except IDLE, DONE and ERR.
- Boundary conditions:
  - N=DEPTH=512 → the final write goes to address 511.
  - idx never exceeds cnt, so there is no address wrap.
  - rx_valid asserted while rx_ready=0 → the byte is ignored. The upstream must hold it.

Optional Feature:
- Macro: IRAM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, the FSM enters CHK and accepts one extra byte.
  - That byte must equal the XOR of all 2N data bytes; header bytes are excluded.
  - Match → DONE. Mismatch → ERR.
  - The running XOR resets in IDLE.
- When undefined:
  - The CHK state and the XOR register are absent.
  - The last WRITE goes directly to DONE.

Decomposition:
- Package iram_loader_pkg holds:
  - the state encoding (IDLE, HDR_LO, DATA_HI, DATA_LO, WRITE, CHK, DONE, ERR, as a 3-bit localparam set);
  - HDR_BYTES=2;
  - BYTES_PER_WORD=2.
- There are no sub-modules. The byte-to-word assembler is small enough to stay in the FSM.

Test Plan:
- Reset, then stream 00 02 12 34 AB CD with rx_valid held high.
  - Response: writes 0x1234@0 and 0xABCD@1, three cycles apart. core_start=1 after the second write.
  - rx_ready=0 during WRITE.
- Header 00 00.
  - Response: error=1, no iram_we, core_start stays 0.
- Header 02 01 (513).
  - Response: error=1, no writes.
- Header 02 00 followed by 512 words of value i.
  - Response: last write is addr 511, data 0x01FF; then DONE.
- Mid-load reset: after 00 03 11 22, assert rst_n=0 for one cycle.
  - Response: all outputs 0, state IDLE.
  - A new stream 00 01 55 66 loads 0x5566@0.
- With IRAM_LOADER_CHECKSUM_EN, stream 00 01 12 34 26.
  - Response: DONE.
  - With a final byte of 27 instead → error=1, core_start=0.

Source files
------------

// File: rtl/iram_loader_pkg.sv
// Shared definitions for the IRAM program loader: FSM state encoding and stream framing constants.
package iram_loader_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHdrLo  = 3'd1,
    StDataHi = 3'd2,
    StDataLo = 3'd3,
    StWrite  = 3'd4,
    StChk    = 3'd5,
    StDone   = 3'd6,
    StErr    = 3'd7
  } state_e;

  // Count header is two bytes, each instruction word is two bytes, both big-endian.
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 2;

endpackage

// File: rtl/iram_loader.sv
// IRAM loader: takes a big-endian byte stream (16-bit word count, then the words), writes each
// word into instruction RAM at 0..N-1 and raises core_start once the image is in.
// Optional: define IRAM_LOADER_CHECKSUM_EN to require a trailing XOR-of-data-bytes checksum byte.
module iram_loader
  import iram_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [15:0]       iram_wdata,
  output logic              core_start,
  output logic              busy,
  output logic              error
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       hdr_cnt;
  logic              accept;
  state_e            last_word_next;

  // Output flags are registered from the next state so every port is a flop output.
  logic ready_q, ready_d;
  logic we_q, we_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic error_q, error_d;

`ifdef IRAM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  assign last_word_next = StChk;
`else
  assign last_word_next = StDone;
`endif

  assign accept  = rx_valid && ready_q;
  assign idx_inc = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign hdr_cnt = {cnt_q[15:8], rx_data};

  // Next-state logic: header capture, byte-to-word assembly and write sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IRAM_LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef IRAM_LOADER_CHECKSUM_EN
        xor_d = '0;
`endif
        if (accept) begin
          cnt_d[15:8] = rx_data;
          state_d     = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          cnt_d[7:0] = rx_data;
          idx_d      = '0;
          if (hdr_cnt == 16'd0 || hdr_cnt > 16'(DEPTH)) state_d = StErr;
          else                                          state_d = StDataHi;
        end
      end
      StDataHi: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = StDataLo;
`ifdef IRAM_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end
      StDataLo: begin
        if (accept) begin
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = {hi_q, rx_data};
          state_d = StWrite;
`ifdef IRAM_LOADER_CHECKSUM_EN
          xor_d   = xor_q ^ rx_data;
`endif
        end
      end
      StWrite: begin
        idx_d   = idx_inc;
        // idx stops at cnt, so the address never wraps.
        state_d = (16'(idx_inc) == cnt_q) ? last_word_next : StDataHi;
      end
      StChk: begin
`ifdef IRAM_LOADER_CHECKSUM_EN
        if (accept) state_d = (rx_data == xor_q) ? StDone : StErr;
`else
        state_d = StErr;
`endif
      end
      StDone, StErr: ;
      default: state_d = StErr;
    endcase
  end

  // Output decode of the next state, registered below.
  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    start_d = 1'b0;
    busy_d  = 1'b1;
    error_d = 1'b0;
    case (state_d)
      StIdle:                             begin ready_d = 1'b1; busy_d = 1'b0; end
      StHdrLo, StDataHi, StDataLo, StChk: ready_d = 1'b1;
      StWrite:                            we_d = 1'b1;
      StDone:                             begin start_d = 1'b1; busy_d = 1'b0; end
      StErr:                              begin error_d = 1'b1; busy_d = 1'b0; end
      default:                            ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef IRAM_LOADER_CHECKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      error_q <= error_d;
`ifdef IRAM_LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign rx_ready   = ready_q;
  assign iram_we    = we_q;
  assign iram_addr  = addr_q;
  assign iram_wdata = wdata_q;
  assign core_start = start_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: normal load, bad headers, full-depth image, mid-load reset,
// ignored bytes after DONE, and (with IRAM_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_iram_loader;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DEPTH  = 512;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              iram_we;
  logic [ADDR_W-1:0] iram_addr;
  logic [15:0]       iram_wdata;
  logic              core_start;
  logic              busy;
  logic              error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit ready_in_write = 1'b0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];
  int                wr_cyc[$];

  iram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .iram_we    (iram_we),
    .iram_addr  (iram_addr),
    .iram_wdata (iram_wdata),
    .core_start (core_start),
    .busy       (busy),
    .error      (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every IRAM write, sampled mid-cycle.
  always @(negedge clock) begin
    if (iram_we) begin
      wr_addr.push_back(iram_addr);
      wr_data.push_back(iram_wdata);
      wr_cyc.push_back(cyc);
      if (rx_ready) ready_in_write = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    ready_in_write = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) check_eq("ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clock);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_outs"},
             {12'd0, 1'(rx_ready), 1'(iram_we), 1'(core_start), 1'(busy), 1'(error), iram_addr},
             32'd0);
    check_eq({tag, "_wdata"}, 32'(iram_wdata), 32'd0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    clear_log();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clock);
    check_eq("idle_ready", 32'(rx_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    clear_log();

    // Two-word image with valid held high throughout
    send_byte(8'h00);
    check_eq("hdr_busy", 32'(busy), 32'd1);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hAB);
    send_byte(8'hCD);
    rx_valid = 1'b0;
    @(negedge clock);
`ifndef IRAM_LOADER_CHECKSUM_EN
    check_eq("t1_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check_eq("t1_a0", 32'(wr_addr[0]), 32'd0);
      check_eq("t1_d0", 32'(wr_data[0]), 32'h1234);
      check_eq("t1_a1", 32'(wr_addr[1]), 32'd1);
      check_eq("t1_d1", 32'(wr_data[1]), 32'hABCD);
      check_eq("t1_gap", 32'(wr_cyc[1] - wr_cyc[0]), 32'd3);
    end
    check_eq("t1_ready_in_write", 32'(ready_in_write), 32'd0);
    check_eq("t1_start", 32'(core_start), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd0);
    check_eq("t1_err", 32'(error), 32'd0);
    check_eq("t1_done_ready", 32'(rx_ready), 32'd0);

    // Bytes offered in DONE are ignored
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    repeat (4) @(negedge clock);
    rx_valid = 1'b0;
    check_eq("done_ignore_nwr", 32'(wr_addr.size()), 32'd2);
    check_eq("done_hold_start", 32'(core_start), 32'd1);
    check_eq("done_hold_err", 32'(error), 32'd0);
    check_eq("done_hold_wdata", 32'(iram_wdata), 32'hABCD);
`endif

    // Zero count
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("zero_err", 32'(error), 32'd1);
    check_eq("zero_start", 32'(core_start), 32'd0);
    check_eq("zero_nwr", 32'(wr_addr.size()), 32'd0);
    check_eq("zero_ready", 32'(rx_ready), 32'd0);

    // Count above DEPTH (513)
    do_reset();
    send_byte(8'h02);
    send_byte(8'h01);
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("over_err", 32'(error), 32'd1);
    check_eq("over_start", 32'(core_start), 32'd0);
    check_eq("over_nwr", 32'(wr_addr.size()), 32'd0);

`ifndef IRAM_LOADER_CHECKSUM_EN
    // Full-depth image: 512 words of value i
    do_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 512; i++) begin
      send_byte(8'(i >> 8));
      send_byte(8'(i & 8'hFF));
    end
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("full_nwr", 32'(wr_addr.size()), 32'd512);
    if (wr_addr.size() == 512) begin
      check_eq("full_a300", 32'(wr_addr[300]), 32'd300);
      check_eq("full_d300", 32'(wr_data[300]), 32'h012C);
      check_eq("full_alast", 32'(wr_addr[511]), 32'd511);
      check_eq("full_dlast", 32'(wr_data[511]), 32'h01FF);
    end
    check_eq("full_start", 32'(core_start), 32'd1);
    check_eq("full_err", 32'(error), 32'd0);
`endif

    // Mid-load reset, then a fresh one-word image
    do_reset();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clock);
    check_outputs_zero("midrst");
    rst_n = 1'b1;
    @(negedge clock);
    clear_log();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
`ifdef IRAM_LOADER_CHECKSUM_EN
    send_byte(8'h33);
`endif
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("reload_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check_eq("reload_a", 32'(wr_addr[0]), 32'd0);
      check_eq("reload_d", 32'(wr_data[0]), 32'h5566);
    end
    check_eq("reload_start", 32'(core_start), 32'd1);

`ifdef IRAM_LOADER_CHECKSUM_EN
    // Checksum match: 0x12 ^ 0x34 = 0x26
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("chk_wait_start", 32'(core_start), 32'd0);
    check_eq("chk_wait_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h26);
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("chk_ok_start", 32'(core_start), 32'd1);
    check_eq("chk_ok_err", 32'(error), 32'd0);
    check_eq("chk_ok_d", 32'(iram_wdata), 32'h1234);

    // Checksum mismatch
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    rx_valid = 1'b0;
    @(negedge clock);
    check_eq("chk_bad_err", 32'(error), 32'd1);
    check_eq("chk_bad_start", 32'(core_start), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
